sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 8, number of storage entries; SHALL equal 2**ADDRESS.
REQ-003 Parameter ADDRESS, default 3, storage address width in bits.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-low.
REQ-006 W_INC  input  1  write request; pushes WR_DATA when sampled high and FULL low.
REQ-007 WR_DATA  input  WIDTH  write data, sampled on rising CLK with W_INC.
REQ-008 R_INC  input  1  read request; pops head word when sampled high and EMPTY low.
REQ-009 RD_DATA  output  WIDTH  head-of-queue word, first-word fall-through.
REQ-010 FULL  output  1  high when DEPTH words are stored.
REQ-011 EMPTY  output  1  high when zero words are stored.

Function
REQ-012 Write pointer and read pointer SHALL each be ADDRESS+1 bits; low ADDRESS bits index storage, MSB is the wrap bit.
REQ-013 Accepted write: mem[wptr[ADDRESS-1:0]] <= WR_DATA, wptr increments by 1 modulo 2**(ADDRESS+1), same edge.
REQ-014 Accepted read: rptr increments by 1 modulo 2**(ADDRESS+1); storage unchanged.
REQ-015 EMPTY SHALL be combinational: wptr == rptr.
REQ-016 FULL SHALL be combinational: MSBs differ and low ADDRESS bits equal.
REQ-017 Flags update in the cycle after the accepting edge (zero extra latency beyond pointer register).
REQ-018 RD_DATA SHALL be combinational mem[rptr[ADDRESS-1:0]]; valid whenever EMPTY low; popping advances it to the next word after the edge.
REQ-019 W_INC while FULL: write ignored, no pointer or storage change, no error output.
REQ-020 R_INC while EMPTY: read ignored, rptr unchanged.
REQ-021 Simultaneous W_INC and R_INC, neither flag set: both accepted, occupancy unchanged, flags unchanged.
REQ-022 Simultaneous when FULL: read accepted, write rejected; FULL deasserts next cycle.
REQ-023 Simultaneous when EMPTY: write accepted, read rejected; EMPTY deasserts next cycle with RD_DATA = written word.
REQ-024 Pointer wrap-around SHALL be seamless; data order strictly first-in first-out across wraps.
REQ-025 W_INC/R_INC held high for multiple cycles SHALL push/pop one word per cycle.

Reset
REQ-026 RST low asynchronously clears wptr and rptr to 0 and all storage entries to 0.
REQ-027 During and after reset: EMPTY=1, FULL=0, RD_DATA=0.
REQ-028 Reset mid-operation discards all stored words; no partial write completes on the reset edge.
REQ-029 Release of RST SHALL be synchronous to CLK in the surrounding system; first accepted operation on the first rising edge with RST high.

Structure
REQ-030 Shared package holds default WIDTH, DEPTH, ADDRESS constants and the DEPTH==2**ADDRESS rule.
REQ-031 Storage SHALL be one sub-module fifo_mem (register array, one synchronous write port, one combinational read port, async clear); pointers and flags in the top.

Verification
REQ-032 Reset, then write 0,1,4,9,16,25,36,49 one per two cycles -> EMPTY falls after first write, RD_DATA=0, FULL rises after eighth write.
REQ-033 After REQ-032, three single reads -> RD_DATA sequence 0,1,4 then 9; FULL falls after first read.
REQ-034 Ninth write (value 64) while FULL -> ignored; eight pops return 0,1,4,9,16,25,36,49, EMPTY after last.
REQ-035 Hold R_INC high three cycles with 5 stored words -> pops exactly 3 words in order, 2 remain, EMPTY low.
REQ-036 Write 12 words / read interleaved across two pointer wraps, simultaneous W_INC+R_INC at full and empty -> order preserved, REQ-022/REQ-023 flag behaviour.
REQ-037 Assert RST with 4 words stored -> immediately EMPTY=1, FULL=0, RD_DATA=0; subsequent write 0xA5 reads back 0xA5.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared FIFO geometry defaults and depth rule
// Holds default WIDTH/DEPTH/ADDRESS and the DEPTH == 2**ADDRESS check used by the top.
package sync_fifo_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_ADDRESS = 3;
    localparam int DEF_DEPTH   = 1 << DEF_ADDRESS;

    // Storage is indexed by the low ADDRESS pointer bits, so the depth must be
    // exactly a power of two matching the address width.
    function automatic bit depth_ok(input int depth, input int address);
        return depth == (1 << address);
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// rtl/sync_fifo_if.sv - push/pop handshake bundle for sync_fifo
// Signals: W_INC, WR_DATA (push side), R_INC (pop request),
// RD_DATA, FULL, EMPTY (status returned by the FIFO).
// master: the FIFO user; slave: the FIFO itself.
interface sync_fifo_if #(
    parameter int WIDTH = sync_fifo_pkg::DEF_WIDTH
);
    logic             W_INC;
    logic [WIDTH-1:0] WR_DATA;
    logic             R_INC;
    logic [WIDTH-1:0] RD_DATA;
    logic             FULL;
    logic             EMPTY;

    modport master (
        output W_INC, WR_DATA, R_INC,
        input  RD_DATA, FULL, EMPTY
    );

    modport slave (
        input  W_INC, WR_DATA, R_INC,
        output RD_DATA, FULL, EMPTY
    );
endinterface

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - FIFO storage array, one sync write port, one comb read port
// Ports: clk, rst_n (async active-low, clears every entry), we/waddr/wdata
// (write on rising clk), raddr/rdata (combinational read).
module fifo_mem #(
    parameter int WIDTH   = sync_fifo_pkg::DEF_WIDTH,
    parameter int DEPTH   = sync_fifo_pkg::DEF_DEPTH,
    parameter int ADDRESS = sync_fifo_pkg::DEF_ADDRESS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [ADDRESS-1:0] waddr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [ADDRESS-1:0] raddr,
    output logic [WIDTH-1:0]   rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Clearing the array on reset makes RD_DATA read zero while the FIFO is
    // freshly reset, instead of exposing stale words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock first-word-fall-through FIFO
// Ports: CLK (rising edge), RST (async active-low), bus (sync_fifo_if.slave):
// W_INC/WR_DATA push, R_INC pop, RD_DATA head word, FULL, EMPTY.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int ADDRESS = DEF_ADDRESS
) (
    input  logic        CLK,
    input  logic        RST,
    sync_fifo_if.slave  bus
);

    if (!depth_ok(DEPTH, ADDRESS)) begin : g_bad_depth
        $error("sync_fifo: DEPTH must equal 2**ADDRESS");
    end

    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [ADDRESS:0] wptr;
    logic [ADDRESS:0] rptr;
    logic             full;
    logic             empty;
    logic             wr_en;
    logic             rd_en;

    assign empty = (wptr == rptr);
    assign full  = (wptr[ADDRESS] != rptr[ADDRESS]) &&
                   (wptr[ADDRESS-1:0] == rptr[ADDRESS-1:0]);

    // Requests against a blocking flag are dropped silently; with both set
    // and neither flag active, both proceed and occupancy holds.
    assign wr_en = bus.W_INC && !full;
    assign rd_en = bus.R_INC && !empty;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_en) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    fifo_mem #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .ADDRESS (ADDRESS)
    ) u_mem (
        .clk   (CLK),
        .rst_n (RST),
        .we    (wr_en),
        .waddr (wptr[ADDRESS-1:0]),
        .wdata (bus.WR_DATA),
        .raddr (rptr[ADDRESS-1:0]),
        .rdata (bus.RD_DATA)
    );

    assign bus.FULL  = full;
    assign bus.EMPTY = empty;

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - self-checking bench for sync_fifo against a queue model
module tb_sync_fifo;

    localparam int W = 8;
    localparam int D = 8;
    localparam int A = 3;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    sync_fifo_if #(.WIDTH(W)) bus ();

    sync_fifo #(
        .WIDTH   (W),
        .DEPTH   (D),
        .ADDRESS (A)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] mq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, " EMPTY"}, 32'(bus.EMPTY), 32'(mq.size() == 0));
        chk({tag, " FULL"},  32'(bus.FULL),  32'(mq.size() == D));
        if (mq.size() > 0) begin
            chk({tag, " RD_DATA"}, 32'(bus.RD_DATA), 32'(mq[0]));
        end
    endtask

    // Drive one cycle of requests, let the model apply the FIFO rules from the
    // occupancy seen before the edge, then check outputs 1 time unit later.
    task automatic cyc(input logic w, input logic r, input logic [W-1:0] d, input string tag);
        int  sz;
        bit  do_w;
        bit  do_r;
        bus.W_INC   = w;
        bus.R_INC   = r;
        bus.WR_DATA = d;
        @(posedge CLK);
        sz   = mq.size();
        do_r = r && (sz > 0);
        do_w = w && (sz < D);
        if (do_r) void'(mq.pop_front());
        if (do_w) mq.push_back(d);
        #1;
        check_state(tag);
    endtask

    initial begin
        logic [W-1:0] v;
        bus.W_INC   = 1'b0;
        bus.R_INC   = 1'b0;
        bus.WR_DATA = '0;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("reset EMPTY",   32'(bus.EMPTY),   32'd1);
        chk("reset FULL",    32'(bus.FULL),    32'd0);
        chk("reset RD_DATA", 32'(bus.RD_DATA), 32'd0);
        RST = 1'b1;

        // Squares written one per two cycles
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, W'(i * i), "wr_sq");
            if (i == 0) begin
                chk("first_wr EMPTY",   32'(bus.EMPTY),   32'd0);
                chk("first_wr RD_DATA", 32'(bus.RD_DATA), 32'd0);
            end
            if (i == 6) chk("pre_full FULL", 32'(bus.FULL), 32'd0);
            cyc(1'b0, 1'b0, '0, "idle");
        end
        chk("after_8 FULL", 32'(bus.FULL), 32'd1);

        // Three single reads
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b1, '0, "rd3");
            if (k == 0) chk("first_rd FULL", 32'(bus.FULL), 32'd0);
            chk("rd3 RD_DATA", 32'(bus.RD_DATA), 32'((k + 1) * (k + 1)));
        end

        // Drain, refill, write while full, then pop all eight
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, '0, "drain");
        chk("drained EMPTY", 32'(bus.EMPTY), 32'd1);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, W'(i * i), "refill");
        cyc(1'b1, 1'b0, 8'd64, "wr_full");
        chk("wr_full FULL", 32'(bus.FULL), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("pop_order", 32'(bus.RD_DATA), 32'(i * i));
            cyc(1'b0, 1'b1, '0, "pop8");
        end
        chk("pop8 EMPTY", 32'(bus.EMPTY), 32'd1);

        // Held R_INC with 5 words stored
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, W'(8'h10 + i), "wr5");
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, '0, "hold_rd");
        chk("hold_rd RD_DATA", 32'(bus.RD_DATA), 32'h13);
        chk("hold_rd EMPTY",   32'(bus.EMPTY),   32'd0);
        chk("hold_rd count",   32'(mq.size()),   32'd2);
        cyc(1'b0, 1'b1, '0, "drain2");
        cyc(1'b0, 1'b1, '0, "drain2");

        // Simultaneous at empty: write wins, read ignored
        cyc(1'b1, 1'b1, 8'h77, "sim_empty");
        chk("sim_empty RD_DATA", 32'(bus.RD_DATA), 32'h77);
        chk("sim_empty EMPTY",   32'(bus.EMPTY),   32'd0);
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, W'(8'h80 + i), "fill");
        // Simultaneous at full: read wins, write ignored
        cyc(1'b1, 1'b1, 8'hEE, "sim_full");
        chk("sim_full FULL", 32'(bus.FULL), 32'd0);
        chk("sim_full RD_DATA", 32'(bus.RD_DATA), 32'h80);
        // Twelve more words interleaved across pointer wraps
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 1'b1, W'(8'hC0 + i), "wrap_both");
            cyc(1'b0, 1'b1, '0, "wrap_rd");
            cyc(1'b1, 1'b0, W'(8'hD0 + i), "wrap_wr");
        end
        while (mq.size() > 0) cyc(1'b0, 1'b1, '0, "wrap_drain");

        // Asynchronous reset with 4 words stored, write held across it
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, W'(8'h40 + i), "pre_rst");
        #1;
        RST = 1'b0;
        #1;
        mq.delete();
        chk("async_rst EMPTY",   32'(bus.EMPTY),   32'd1);
        chk("async_rst FULL",    32'(bus.FULL),    32'd0);
        chk("async_rst RD_DATA", 32'(bus.RD_DATA), 32'd0);
        bus.W_INC   = 1'b1;
        bus.WR_DATA = 8'h33;
        @(posedge CLK);
        #1;
        chk("in_rst EMPTY", 32'(bus.EMPTY), 32'd1);
        bus.W_INC = 1'b0;
        RST = 1'b1;
        cyc(1'b1, 1'b0, 8'hA5, "post_rst_wr");
        chk("post_rst RD_DATA", 32'(bus.RD_DATA), 32'hA5);
        cyc(1'b0, 1'b1, '0, "post_rst_rd");

        // Randomized traffic, biased toward filling then toward draining
        for (int i = 0; i < 400; i++) begin
            v = W'($urandom);
            if (i < 200)
                cyc(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3), v, "rand_fill");
            else
                cyc(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 7), v, "rand_drain");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
